// File: rtl/int_controller.sv
// Priority interrupt controller: edge-latched pending bits, IDLE/REQ/SERVICE handshake.
// Optional per-source enable mask when INTC_MASK_EN is defined.
module int_controller #(
  parameter int          N_SRC    = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic             int_ack,
  input  logic             int_done,
`ifdef INTC_MASK_EN
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
`endif
  output logic             int_sig,
  output logic [31:0]      int_vector,
  output logic [2:0]       active_id,
  output logic             busy,
  output logic [N_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] arm_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic             int_sig_q, int_sig_d;
  logic             busy_q, busy_d;
  logic [2:0]       active_id_q, active_id_d;
  logic [31:0]      int_vector_q, int_vector_d;
  logic [N_SRC-1:0] mask_s;
  logic [N_SRC-1:0] edge_s;
  logic [N_SRC-1:0] eligible_s;
  logic [N_SRC-1:0] clr_s;
  logic [2:0]       winner_s;

  function automatic logic [2:0] pick_lowest(input logic [N_SRC-1:0] v);
    pick_lowest = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        pick_lowest = 3'(i);
      end
    end
  endfunction

`ifdef INTC_MASK_EN
  logic [N_SRC-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q <= {N_SRC{1'b1}};
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end else begin
      mask_q <= mask_q;
    end
  end

  assign mask_s = mask_q;
`else
  assign mask_s = {N_SRC{1'b1}};
`endif

  // A source must be seen low once after reset before its rising edges count,
  // so a line held high across reset release does not raise a spurious event.
  assign edge_s     = irq & ~irq_q & arm_q;
  assign eligible_s = pending_q & mask_s;
  assign winner_s   = pick_lowest(eligible_s);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|eligible_s) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SERVICE;
        end else begin
          state_d = REQ;
        end
      end
      SERVICE: begin
        if (int_done) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so int_sig rises and falls on the transition edge.
  always_comb begin
    int_sig_d    = (state_d == REQ);
    busy_d       = (state_d != IDLE);
    active_id_d  = active_id_q;
    int_vector_d = int_vector_q;
    clr_s        = {N_SRC{1'b0}};
    if ((state_q == IDLE) && (state_d == REQ)) begin
      active_id_d  = winner_s;
      int_vector_d = VEC_BASE + {25'd0, winner_s, 4'd0};
    end else begin
      active_id_d  = active_id_q;
      int_vector_d = int_vector_q;
    end
    if ((state_q == REQ) && int_ack) begin
      clr_s = {{(N_SRC-1){1'b0}}, 1'b1} << active_id_q;
    end else begin
      clr_s = {N_SRC{1'b0}};
    end
  end

  // A new edge outranks a same-cycle clear.
  always_comb begin
    pending_d = (pending_q & ~clr_s) | edge_s;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_q        <= {N_SRC{1'b0}};
      arm_q        <= {N_SRC{1'b0}};
      pending_q    <= {N_SRC{1'b0}};
      int_sig_q    <= 1'b0;
      busy_q       <= 1'b0;
      active_id_q  <= 3'd0;
      int_vector_q <= VEC_BASE;
    end else begin
      irq_q        <= irq;
      arm_q        <= arm_q | ~irq;
      pending_q    <= pending_d;
      int_sig_q    <= int_sig_d;
      busy_q       <= busy_d;
      active_id_q  <= active_id_d;
      int_vector_q <= int_vector_d;
    end
  end

  assign int_sig    = int_sig_q;
  assign busy       = busy_q;
  assign active_id  = active_id_q;
  assign int_vector = int_vector_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed self-checking bench for int_controller (N_SRC=4, VEC_BASE=32'h100).
// Observed tuple: {int_sig, busy, active_id, pending, int_vector}.
module tb_int_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  irq;
  logic        int_ack;
  logic        int_done;
  logic        int_sig;
  logic [31:0] int_vector;
  logic [2:0]  active_id;
  logic        busy;
  logic [3:0]  pending;
`ifdef INTC_MASK_EN
  logic        mask_we;
  logic [3:0]  mask_wdata;
`endif

  int vectors;
  int miscompares;

  logic [40:0] obs_w;
  logic [40:0] exp_v;

  int_controller #(.N_SRC(4), .VEC_BASE(32'h0000_0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .int_ack    (int_ack),
    .int_done   (int_done),
`ifdef INTC_MASK_EN
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
`endif
    .int_sig    (int_sig),
    .int_vector (int_vector),
    .active_id  (active_id),
    .busy       (busy),
    .pending    (pending)
  );

  assign obs_w = {int_sig, busy, active_id, pending, int_vector};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; irq = 4'b0000; int_ack = 1'b0; int_done = 1'b0;
    tick; tick;
    exp_v = {1'b0, 1'b0, 3'd0, 4'b0000, 32'h0000_0100};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL reset_state got %h exp %h", obs_w, exp_v); end
    rst = 1'b1;
    tick;
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL reset_release got %h exp %h", obs_w, exp_v); end
  endtask

  task automatic test_basic;
    irq = 4'b0100;
    tick;
    exp_v = {1'b0, 1'b0, 3'd0, 4'b0100, 32'h0000_0100};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL basic_pending got %h exp %h", obs_w, exp_v); end
    tick;
    exp_v = {1'b1, 1'b1, 3'd2, 4'b0100, 32'h0000_0120};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL basic_req got %h exp %h", obs_w, exp_v); end
    int_ack = 1'b1;
    tick;
    exp_v = {1'b0, 1'b1, 3'd2, 4'b0000, 32'h0000_0120};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL basic_ack got %h exp %h", obs_w, exp_v); end
    tick;
    int_ack = 1'b0;
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL basic_ack_in_service got %h exp %h", obs_w, exp_v); end
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    exp_v = {1'b0, 1'b0, 3'd2, 4'b0000, 32'h0000_0120};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL basic_done got %h exp %h", obs_w, exp_v); end
    tick; tick;
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL basic_level_once got %h exp %h", obs_w, exp_v); end
    irq = 4'b0000;
    tick;
  endtask

  task automatic test_priority;
    irq = 4'b1010;
    tick; tick;
    exp_v = {1'b1, 1'b1, 3'd1, 4'b1010, 32'h0000_0110};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL prio_first got %h exp %h", obs_w, exp_v); end
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL prio_done_in_req got %h exp %h", obs_w, exp_v); end
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    exp_v = {1'b0, 1'b1, 3'd1, 4'b1000, 32'h0000_0110};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL prio_ack1 got %h exp %h", obs_w, exp_v); end
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    exp_v = {1'b0, 1'b0, 3'd1, 4'b1000, 32'h0000_0110};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL prio_idle got %h exp %h", obs_w, exp_v); end
    tick;
    exp_v = {1'b1, 1'b1, 3'd3, 4'b1000, 32'h0000_0130};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL prio_second got %h exp %h", obs_w, exp_v); end
    irq = 4'b1011;
    tick;
    exp_v = {1'b1, 1'b1, 3'd3, 4'b1001, 32'h0000_0130};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL prio_frozen got %h exp %h", obs_w, exp_v); end
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    tick;
    exp_v = {1'b1, 1'b1, 3'd0, 4'b0001, 32'h0000_0100};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL prio_third got %h exp %h", obs_w, exp_v); end
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    irq = 4'b0000;
    tick;
  endtask

  task automatic test_nesting;
    irq = 4'b0100;
    tick; tick;
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    irq = 4'b0101;
    tick; tick;
    exp_v = {1'b0, 1'b1, 3'd2, 4'b0001, 32'h0000_0120};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL nest_no_sig got %h exp %h", obs_w, exp_v); end
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    tick;
    exp_v = {1'b1, 1'b1, 3'd0, 4'b0001, 32'h0000_0100};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL nest_rerequest got %h exp %h", obs_w, exp_v); end
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    irq = 4'b0000;
    tick;
  endtask

  task automatic test_back_to_back;
    irq = 4'b0010;
    tick; tick;
    irq = 4'b0000;
    tick;
    exp_v = {1'b1, 1'b1, 3'd1, 4'b0010, 32'h0000_0110};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL b2b_req got %h exp %h", obs_w, exp_v); end
    irq = 4'b0010;
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    exp_v = {1'b0, 1'b1, 3'd1, 4'b0010, 32'h0000_0110};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL b2b_set_wins got %h exp %h", obs_w, exp_v); end
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    tick;
    exp_v = {1'b1, 1'b1, 3'd1, 4'b0010, 32'h0000_0110};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL b2b_rerequest got %h exp %h", obs_w, exp_v); end
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    irq = 4'b0000;
    tick;
  endtask

  task automatic test_reset_abort;
    irq = 4'b1000;
    tick; tick;
    irq = 4'b0001;
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    tick;
    exp_v = {1'b1, 1'b1, 3'd0, 4'b0001, 32'h0000_0100};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL abort_req got %h exp %h", obs_w, exp_v); end
    rst = 1'b0;
    tick;
    exp_v = {1'b0, 1'b0, 3'd0, 4'b0000, 32'h0000_0100};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL abort_reset got %h exp %h", obs_w, exp_v); end
    rst = 1'b1;
    tick; tick; tick;
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL abort_held_high got %h exp %h", obs_w, exp_v); end
    irq = 4'b0000;
    tick;
    irq = 4'b0001;
    tick; tick;
    exp_v = {1'b1, 1'b1, 3'd0, 4'b0001, 32'h0000_0100};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL abort_retoggle got %h exp %h", obs_w, exp_v); end
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    irq = 4'b0000;
    tick;
  endtask

`ifdef INTC_MASK_EN
  task automatic test_mask;
    mask_we = 1'b1; mask_wdata = 4'b1110;
    tick;
    mask_we = 1'b0;
    irq = 4'b0001;
    tick; tick;
    exp_v = {1'b0, 1'b0, 3'd0, 4'b0001, 32'h0000_0100};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL mask_blocked got %h exp %h", obs_w, exp_v); end
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick;
    mask_we = 1'b0;
    tick;
    exp_v = {1'b1, 1'b1, 3'd0, 4'b0001, 32'h0000_0100};
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL mask_enabled got %h exp %h", obs_w, exp_v); end
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick;
    vectors++;
    if (obs_w !== exp_v) begin miscompares++; $display("FAIL mask_write_in_req got %h exp %h", obs_w, exp_v); end
    mask_wdata = 4'b1111;
    int_ack = 1'b1;
    tick;
    mask_we = 1'b0;
    int_ack = 1'b0;
    int_done = 1'b1;
    tick;
    int_done = 1'b0;
    irq = 4'b0000;
    tick;
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
`ifdef INTC_MASK_EN
    mask_we = 1'b0;
    mask_wdata = 4'b1111;
`endif
    test_reset;
    test_basic;
    test_priority;
    test_nesting;
    test_back_to_back;
    test_reset_abort;
`ifdef INTC_MASK_EN
    test_mask;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
